// File: rtl/sonic_obstacle_guard.sv
// sonic_obstacle_guard
//   Filters the sonic sensor distance (cm) and classifies it into
//   CLEAR / WARN / STOP with hysteresis and debounce for the speed limiter.
//   Optional feature macro: SONIC_STALE_STOP_EN (force STOP after STALE_N
//   consecutive invalid samples).
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   distance   in   [19:0] distance from sonic block (asynchronous domain)
//   filt_dist  out  [19:0] 4-tap moving average, cm
//   warn       out  state is WARN or STOP
//   stop       out  state is STOP
//   upd        out  one-cycle pulse when filt_dist/state have been updated
//   reading_ok out  last sample was nonzero
module sonic_obstacle_guard #(
    parameter int unsigned SAMPLE_DIV = 10_000_000,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned WARN_CM    = 40,
    parameter int unsigned STOP_CM    = 20,
    parameter int unsigned HYST_CM    = 5,
    parameter int unsigned DEBOUNCE   = 2
`ifdef SONIC_STALE_STOP_EN
    ,
    parameter int unsigned STALE_N    = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] distance,
    output logic [19:0] filt_dist,
    output logic        warn,
    output logic        stop,
    output logic        upd,
    output logic        reading_ok
);

    localparam int unsigned DW    = 20;
    localparam int unsigned SW    = 22;
    localparam int unsigned TW    = $clog2(SAMPLE_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
`ifdef SONIC_STALE_STOP_EN
    localparam int unsigned STW   = $clog2(STALE_N + 1);
`endif

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_WARN  = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    logic [DW-1:0]    r_sync1, r_sync2, r_stable;
    logic [TW-1:0]    r_tick_cnt;
    logic             r_v1, r_v2, r_good;
    logic [DW-1:0]    r_samp;
    logic [DW-1:0]    r_tap [3];
    logic [SW-1:0]    r_sum;
    logic [DW-1:0]    r_filt;
    logic             r_upd, r_ok, r_warn, r_stop;
    state_t           r_state, r_prev_d;
    logic [CNT_W-1:0] r_cnt;
`ifdef SONIC_STALE_STOP_EN
    logic [STW-1:0]   r_stale, w_stale_nxt, w_stale_inc;
`endif

    logic             w_tick;
    logic [DW-1:0]    w_sat, w_avg, w_filt_nxt;
    logic [SW-1:0]    w_sum;
    state_t           w_state_nxt, w_prev_nxt, w_zone;
    logic [CNT_W-1:0] w_cnt_nxt, w_cnt_try;

    assign w_tick = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
    assign w_sat  = (r_stable > DW'(MAX_CM)) ? DW'(MAX_CM) : r_stable;
    // Newest sample plus the three most recent taps.
    assign w_sum  = SW'(r_samp) + SW'(r_tap[0]) + SW'(r_tap[1]) + SW'(r_tap[2]);
    assign w_avg  = DW'(r_sum >> 2);

    // Two-stage synchronizer; only accept a value once both stages agree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
        end else begin
            r_sync1 <= distance;
            r_sync2 <= r_sync1;
            if (r_sync1 == r_sync2) r_stable <= r_sync2;
        end
    end

    // Sample tick, capture (T), tap shift and sum (T+1), upd flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_good     <= 1'b0;
            r_samp     <= '0;
            r_ok       <= 1'b0;
            r_upd      <= 1'b0;
            r_sum      <= SW'(4 * MAX_CM);
            for (int i = 0; i < 3; i++) r_tap[i] <= DW'(MAX_CM);
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_v1       <= w_tick;
            r_v2       <= r_v1;
            r_upd      <= r_v2;
            if (w_tick) r_samp <= w_sat;
            if (r_v1) begin
                r_good <= (r_samp != '0);
                r_ok   <= (r_samp != '0);
                if (r_samp != '0) begin
                    r_tap[0] <= r_samp;
                    r_tap[1] <= r_tap[0];
                    r_tap[2] <= r_tap[1];
                    r_sum    <= w_sum;
                end
            end
        end
    end

    // State register (filter output, zone state, debounce tracking).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_filt   <= DW'(MAX_CM);
            r_state  <= ST_CLEAR;
            r_prev_d <= ST_CLEAR;
            r_cnt    <= '0;
            r_warn   <= 1'b0;
            r_stop   <= 1'b0;
`ifdef SONIC_STALE_STOP_EN
            r_stale  <= '0;
`endif
        end else begin
            r_filt   <= w_filt_nxt;
            r_state  <= w_state_nxt;
            r_prev_d <= w_prev_nxt;
            r_cnt    <= w_cnt_nxt;
            r_warn   <= (w_state_nxt != ST_CLEAR);
            r_stop   <= (w_state_nxt == ST_STOP);
`ifdef SONIC_STALE_STOP_EN
            r_stale  <= w_stale_nxt;
`endif
        end
    end

    // Zone evaluation and debounce at T+2.
    always_comb begin
        w_filt_nxt  = r_filt;
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev_d;
        w_cnt_nxt   = r_cnt;
        w_zone      = r_state;
        w_cnt_try   = '0;
`ifdef SONIC_STALE_STOP_EN
        w_stale_nxt = r_stale;
        w_stale_inc = (r_stale == STW'(STALE_N)) ? r_stale : r_stale + STW'(1);
`endif
        if (r_v2) begin
            if (r_good) begin
                w_filt_nxt = w_avg;
                if (w_avg < DW'(STOP_CM)) begin
                    w_zone = ST_STOP;
                end else if (w_avg < DW'(WARN_CM)) begin
                    w_zone = (r_state == ST_STOP && w_avg < DW'(STOP_CM + HYST_CM))
                             ? ST_STOP : ST_WARN;
                end else if (r_state != ST_CLEAR && w_avg < DW'(WARN_CM + HYST_CM)) begin
                    w_zone = (r_state == ST_STOP && w_avg < DW'(STOP_CM + HYST_CM))
                             ? ST_STOP : ST_WARN;
                end else begin
                    w_zone = ST_CLEAR;
                end
                w_prev_nxt = w_zone;
                if (w_zone == r_state) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_try = (w_zone == r_prev_d) ? r_cnt + CNT_W'(1) : CNT_W'(1);
                    if (w_cnt_try >= CNT_W'(DEBOUNCE)) begin
                        w_state_nxt = w_zone;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_try;
                    end
                end
`ifdef SONIC_STALE_STOP_EN
                w_stale_nxt = '0;
`endif
            end else begin
`ifdef SONIC_STALE_STOP_EN
                // Too many invalid samples in a row: fail safe to STOP.
                w_stale_nxt = w_stale_inc;
                if (w_stale_inc == STW'(STALE_N)) begin
                    w_state_nxt = ST_STOP;
                    w_cnt_nxt   = '0;
                end
`endif
            end
        end
    end

    assign filt_dist  = r_filt;
    assign warn       = r_warn;
    assign stop       = r_stop;
    assign upd        = r_upd;
    assign reading_ok = r_ok;

endmodule

// File: tb/tb_sonic_obstacle_guard.sv
// Testbench for sonic_obstacle_guard with a behavioural reference model.
module tb_sonic_obstacle_guard;

    localparam int SDIV  = 16;
    localparam int MAXC  = 400;
    localparam int WARNC = 40;
    localparam int STOPC = 20;
    localparam int HYST  = 5;
    localparam int DEB   = 2;
`ifdef SONIC_STALE_STOP_EN
    localparam int STALE = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] distance = '0;
    logic [19:0] filt_dist;
    logic        warn, stop, upd, reading_ok;

    sonic_obstacle_guard #(
        .SAMPLE_DIV(SDIV)
`ifdef SONIC_STALE_STOP_EN
        , .STALE_N(STALE)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .distance  (distance),
        .filt_dist (filt_dist),
        .warn      (warn),
        .stop      (stop),
        .upd       (upd),
        .reading_ok(reading_ok)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: list of last four valid readings, zone 0/1/2.
    int m_hist[4];
    int m_filt, m_ok, m_zone, run_d, run_len, inv_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_hist[i] = MAXC;
        m_filt = MAXC; m_ok = 0; m_zone = 0; run_d = 0; run_len = 0; inv_run = 0;
    endtask

    task automatic model_sample(input int d);
        int s, total, want, lim_stop, lim_warn;
        s = (d > MAXC) ? MAXC : d;
        if (s == 0) begin
            m_ok = 0;
            inv_run++;
`ifdef SONIC_STALE_STOP_EN
            if (inv_run >= STALE) begin
                m_zone = 2;
                run_len = 0;
            end
`endif
        end else begin
            m_ok = 1;
            inv_run = 0;
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s;
            total = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
            m_filt = total / 4;
            // Release thresholds sit HYST above the entry thresholds.
            lim_stop = (m_zone == 2) ? STOPC + HYST : STOPC;
            lim_warn = (m_zone != 0) ? WARNC + HYST : WARNC;
            want = (m_filt < lim_stop) ? 2 : (m_filt < lim_warn) ? 1 : 0;
            if (want == m_zone)     run_len = 0;
            else if (want == run_d) run_len++;
            else                    run_len = 1;
            run_d = want;
            if (run_len >= DEB) begin
                m_zone = want;
                run_len = 0;
            end
        end
    endtask

    task automatic step(input int d, input string tag);
        bit seen;
        distance = 20'(d);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (upd) seen = 1'b1;
        end
        chk({tag, "_upd_seen"}, 32'(seen), 32'd1);
        model_sample(d);
        chk({tag, "_filt"}, 32'(filt_dist), 32'(m_filt));
        chk({tag, "_warn"}, 32'(warn), 32'(m_zone != 0));
        chk({tag, "_stop"}, 32'(stop), 32'(m_zone == 2));
        chk({tag, "_ok"},   32'(reading_ok), 32'(m_ok));
        @(negedge clk);
        chk({tag, "_upd_pulse"}, 32'(upd), 32'd0);
    endtask

    initial begin
        int ap[4];
        int d, r;
        bit any_upd;
        ap[0] = 307; ap[1] = 215; ap[2] = 122; ap[3] = 30;

        // Reset
        model_reset();
        distance = 20'd30;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_filt", 32'(filt_dist), 32'd400);
        chk("rst_warn", 32'(warn), 32'd0);
        chk("rst_stop", 32'(stop), 32'd0);
        chk("rst_upd",  32'(upd), 32'd0);
        chk("rst_ok",   32'(reading_ok), 32'd0);
        rst = 1'b1;

        // Approach at constant 30 cm
        for (int i = 0; i < 4; i++) begin
            step(30, "approach");
            chk("approach_const", 32'(filt_dist), 32'(ap[i]));
        end
        step(30, "approach5");

        // Move into STOP
        for (int i = 0; i < 4; i++) step(10, "stop");
        // Hysteresis hold near 22 cm, then release above STOP+HYST
        for (int i = 0; i < 4; i++) step(22, "hyst_hold");
        for (int i = 0; i < 4; i++) step(26, "hyst_rel");

        // Invalid readings
        for (int i = 0; i < 3; i++) step(0, "invalid");
        for (int i = 0; i < 4; i++) step(50, "recover");

        // Randomized sequence
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      d = 0;
            else if (r == 1) d = int'($urandom_range(400, 1048575));
            else             d = int'($urandom_range(1, 80));
            step(d, "rand");
        end

        // Mid-operation reset between capture and update
        step(15, "pre_midrst");
        repeat (13) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk("midrst_filt", 32'(filt_dist), 32'd400);
        chk("midrst_warn", 32'(warn), 32'd0);
        chk("midrst_stop", 32'(stop), 32'd0);
        chk("midrst_upd",  32'(upd), 32'd0);
        chk("midrst_ok",   32'(reading_ok), 32'd0);
        distance = 20'd30;
        any_upd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (upd) any_upd = 1'b1;
        end
        chk("midrst_no_upd", 32'(any_upd), 32'd0);
        step(30, "post_midrst");
        chk("post_midrst_const", 32'(filt_dist), 32'd307);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
